sprite_anim_addr: RTL

//  Upstream address generator for a fighter sprite's ROM and palette stage.

---
 rtl/sprite_anim_addr.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/sprite_anim_addr.sv
// Sprite ROM address generator: places a multi-frame, optionally mirrored sprite and
// sequences a triggered attack animation one video frame at a time. Address path has 1 cycle latency.
module sprite_anim_addr #(
    parameter int SPR_W          = 64,
    parameter int SPR_H          = 64,
    parameter int NUM_FRAMES     = 4,
    parameter int TICKS_PER_FRM  = 6,
    parameter int COOLDOWN_TICKS = 8,
    parameter int ADDR_W         = 14,
    localparam int FI_W = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
    input  logic              vga_clk,
    input  logic              reset,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              frame_tick,
    input  logic              trigger,
    input  logic [9:0]        pos_x,
    input  logic [9:0]        pos_y,
    input  logic              facing_left,
    output logic [ADDR_W-1:0] rom_address,
    output logic              sprite_on,
    output logic [FI_W-1:0]   frame_idx,
    output logic              anim_busy,
    output logic              anim_done
);

    localparam int TC_W = (TICKS_PER_FRM > 1) ? $clog2(TICKS_PER_FRM) : 1;
    localparam int CD_W = (COOLDOWN_TICKS > 1) ? $clog2(COOLDOWN_TICKS) : 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PLAY     = 2'd1,
        COOLDOWN = 2'd2
    } state_t;

    state_t            r_state,     w_state_nxt;
    logic [FI_W-1:0]   r_frame_idx, w_frame_nxt;
    logic [TC_W-1:0]   r_tick_cnt,  w_tick_nxt;
    logic [CD_W-1:0]   r_cd_cnt,    w_cd_nxt;
    logic              r_pending,   w_pending_nxt;
    logic              r_done,      w_done_nxt;

    logic [9:0]        r_sx;
    logic [9:0]        r_sy;
    logic              r_facing;

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_frame_idx <= '0;
            r_tick_cnt  <= '0;
            r_cd_cnt    <= '0;
            r_pending   <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_frame_idx <= w_frame_nxt;
            r_tick_cnt  <= w_tick_nxt;
            r_cd_cnt    <= w_cd_nxt;
            r_pending   <= w_pending_nxt;
            r_done      <= w_done_nxt;
        end
    end

    // Sequencer only moves on frame_tick so a whole video frame shows one animation frame.
    always_comb begin
        w_state_nxt   = r_state;
        w_frame_nxt   = r_frame_idx;
        w_tick_nxt    = r_tick_cnt;
        w_cd_nxt      = r_cd_cnt;
        w_pending_nxt = r_pending;
        w_done_nxt    = 1'b0;
        case (r_state)
            IDLE: begin
                if (frame_tick && (trigger || r_pending)) begin
                    w_state_nxt   = PLAY;
                    w_frame_nxt   = '0;
                    w_tick_nxt    = '0;
                    w_pending_nxt = 1'b0;
                end else if (trigger) begin
                    w_pending_nxt = 1'b1;
                end
            end
            PLAY: begin
                if (frame_tick) begin
                    if (r_tick_cnt != TC_W'(TICKS_PER_FRM - 1)) begin
                        w_tick_nxt = r_tick_cnt + TC_W'(1);
                    end else begin
                        w_tick_nxt = '0;
                        if (r_frame_idx != FI_W'(NUM_FRAMES - 1)) begin
                            w_frame_nxt = r_frame_idx + FI_W'(1);
                        end else begin
                            w_frame_nxt = '0;
                            w_cd_nxt    = '0;
                            w_done_nxt  = 1'b1;
                            w_state_nxt = (COOLDOWN_TICKS == 0) ? IDLE : COOLDOWN;
                        end
                    end
                end
            end
            COOLDOWN: begin
                if (frame_tick) begin
                    if (r_cd_cnt == CD_W'(COOLDOWN_TICKS - 1)) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_cd_nxt = r_cd_cnt + CD_W'(1);
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Position/facing shadowed at frame_tick so mid-frame updates never tear the sprite.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            r_sx     <= '0;
            r_sy     <= '0;
            r_facing <= 1'b0;
        end else if (frame_tick) begin
            r_sx     <= pos_x;
            r_sy     <= pos_y;
            r_facing <= facing_left;
        end
    end

    logic [10:0]       w_dx;
    logic [10:0]       w_dy;
    logic [10:0]       w_col;
    logic              w_inside;
    logic [ADDR_W-1:0] w_addr;

    // 11-bit sums: a box past the right/bottom edge clips instead of wrapping to column 0.
    assign w_dx     = {1'b0, DrawX} - {1'b0, r_sx};
    assign w_dy     = {1'b0, DrawY} - {1'b0, r_sy};
    assign w_inside = (DrawX >= r_sx) && ({1'b0, DrawX} < ({1'b0, r_sx} + 11'(SPR_W))) &&
                      (DrawY >= r_sy) && ({1'b0, DrawY} < ({1'b0, r_sy} + 11'(SPR_H)));
    assign w_col    = r_facing ? (11'(SPR_W - 1) - w_dx) : w_dx;
    assign w_addr   = ADDR_W'(r_frame_idx) * ADDR_W'(SPR_W * SPR_H)
                    + ADDR_W'(w_dy) * ADDR_W'(SPR_W)
                    + ADDR_W'(w_col);

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            rom_address <= '0;
            sprite_on   <= 1'b0;
        end else begin
            rom_address <= w_inside ? w_addr : '0;
            sprite_on   <= w_inside;
        end
    end

    assign frame_idx = r_frame_idx;
    assign anim_busy = (r_state != IDLE);
    assign anim_done = r_done;

endmodule
